// File: rtl/fb_pkg.sv
// Shared types for the frame-buffer pixel port: engine states, bus widths and
// the posted command format.
package fb_pkg;
    localparam int PX_ADDR_W = 16;
    localparam int PX_DATA_W = 24;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_ACK_WAIT = 2'd2
    } px_state_e;

    typedef struct packed {
        logic                 write;
        logic [PX_ADDR_W-1:0] addr;
        logic [PX_DATA_W-1:0] wdata;
    } px_cmd_t;
endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit level synchroniser: a STAGES-deep flop chain with asynchronous
// active-low reset.
module cdc_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];
endmodule

// File: rtl/fb_pixel_master.sv
// Initiator for the four-phase px_request_a / px_ready handshake: one posted
// command slot, a request engine with timeout, and read-data capture.
module fb_pixel_master
    import fb_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_valid,
    output logic                 cpu_ready,
    input  logic                 cpu_write,
    input  logic [PX_ADDR_W-1:0] cpu_addr,
    input  logic [PX_DATA_W-1:0] cpu_wdata,
    output logic                 cpu_wdone,
    output logic                 cpu_rvalid,
    output logic [PX_DATA_W-1:0] cpu_rdata,
    output logic                 cpu_err,
    output logic                 px_request_a,
    output logic                 px_write,
    output logic [PX_ADDR_W-1:0] px_address,
    output logic [PX_DATA_W-1:0] px_write_data,
    input  logic                 px_ready,
    input  logic [PX_DATA_W-1:0] px_read_data,
    output logic [1:0]           dbg_state
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    // Handshake: a command moves into the slot on a cycle where cpu_valid and
    // cpu_ready are both 1; cpu_ready is held off only while the slot is full
    // and the engine cannot take it this cycle.
    px_state_e            state_q, state_d;
    logic                 slot_full_q, slot_full_d;
    px_cmd_t              slot_cmd_q, slot_cmd_d;
    px_cmd_t              px_cmd_q, px_cmd_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
    logic                 req_q, req_d;
    logic                 wdone_q, wdone_d;
    logic                 rvalid_q, rvalid_d;
    logic                 err_q, err_d;
    logic [PX_DATA_W-1:0] rdata_q, rdata_d;
    logic                 rdy_s;
    logic                 take;
    logic                 accept;

    cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_rdy_sync (
        .clk   (clk),
        .rst_n (reset),
        .d     (px_ready),
        .q     (rdy_s)
    );

    // A new request is withheld while the previous acknowledge is still seen.
    assign take      = (state_q == ST_IDLE) && slot_full_q && !rdy_s;
    assign cpu_ready = !slot_full_q || take;
    assign accept    = cpu_valid && cpu_ready;

    always_comb begin
        state_d     = state_q;
        slot_full_d = slot_full_q;
        slot_cmd_d  = slot_cmd_q;
        px_cmd_d    = px_cmd_q;
        req_d       = req_q;
        rdata_d     = rdata_q;
        wdone_d     = 1'b0;
        rvalid_d    = 1'b0;
        err_d       = 1'b0;
        cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        cnt_d       = cnt_q;

        if (take) begin
            slot_full_d = 1'b0;
        end
        if (accept) begin
            slot_full_d      = 1'b1;
            slot_cmd_d.write = cpu_write;
            slot_cmd_d.addr  = cpu_addr;
            slot_cmd_d.wdata = cpu_wdata;
        end

        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    px_cmd_d = slot_cmd_q;
                    req_d    = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_inc;
                // px_read_data has been stable for longer than rdy_s has been high.
                if (rdy_s) begin
                    req_d   = 1'b0;
                    state_d = ST_ACK_WAIT;
                    if (px_cmd_q.write) begin
                        wdone_d = 1'b1;
                    end else begin
                        rvalid_d = 1'b1;
                        rdata_d  = px_read_data;
                    end
                end else if (cnt_inc == CNT_MAX) begin
                    req_d    = 1'b0;
                    state_d  = ST_ACK_WAIT;
                    err_d    = 1'b1;
                    wdone_d  = px_cmd_q.write;
                    rvalid_d = !px_cmd_q.write;
                    if (!px_cmd_q.write) begin
                        rdata_d = '0;
                    end
                end
            end
            ST_ACK_WAIT: begin
                if (!rdy_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            slot_full_q <= 1'b0;
            slot_cmd_q  <= '0;
            px_cmd_q    <= '0;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            wdone_q     <= 1'b0;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            slot_full_q <= slot_full_d;
            slot_cmd_q  <= slot_cmd_d;
            px_cmd_q    <= px_cmd_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            wdone_q     <= wdone_d;
            rvalid_q    <= rvalid_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
        end
    end

    assign cpu_wdone     = wdone_q;
    assign cpu_rvalid    = rvalid_q;
    assign cpu_err       = err_q;
    assign cpu_rdata     = rdata_q;
    assign px_request_a  = req_q;
    assign px_write      = px_cmd_q.write;
    assign px_address    = px_cmd_q.addr;
    assign px_write_data = px_cmd_q.wdata;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_fb_pixel_master.sv
// Bench for fb_pixel_master: random commands against a pixel-memory model, a
// responder in an unrelated pixel clock, and a response scoreboard.
module tb_fb_pixel_master;
    localparam int TO = 16;
    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        pclk = 1'b0;
    logic        reset;
    logic        cpu_valid, cpu_ready, cpu_write;
    logic [15:0] cpu_addr;
    logic [23:0] cpu_wdata;
    logic        cpu_wdone, cpu_rvalid, cpu_err;
    logic [23:0] cpu_rdata;
    logic        px_request_a, px_write;
    logic [15:0] px_address;
    logic [23:0] px_write_data;
    logic        px_ready;
    logic [23:0] px_read_data;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;
    always #7 pclk = ~pclk;

    fb_pixel_master #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_valid     (cpu_valid),
        .cpu_ready     (cpu_ready),
        .cpu_write     (cpu_write),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_wdone     (cpu_wdone),
        .cpu_rvalid    (cpu_rvalid),
        .cpu_rdata     (cpu_rdata),
        .cpu_err       (cpu_err),
        .px_request_a  (px_request_a),
        .px_write      (px_write),
        .px_address    (px_address),
        .px_write_data (px_write_data),
        .px_ready      (px_ready),
        .px_read_data  (px_read_data),
        .dbg_state     (dbg_state)
    );

    typedef struct {
        logic        write;
        logic        err;
        logic [23:0] rdata;
    } resp_t;

    typedef struct {
        logic        write;
        logic [15:0] addr;
        logic [23:0] wdata;
    } pxc_t;

    int          checks = 0;
    int          errors = 0;
    resp_t       exp_q[$];
    pxc_t        px_exp_q[$];
    logic [23:0] model_mem[int];
    logic [23:0] pix_mem[int];
    logic [23:0] last_rdata = 24'h0;
    logic        rsp_en = 1'b1;
    logic        rsp_ready = 1'b0;
    logic        spur = 1'b0;
    logic [23:0] rsp_data = 24'h0;
    logic        prev_req = 1'b0;
    resp_t       mon_r;
    pxc_t        rsp_c;

    assign px_ready     = rsp_ready | spur;
    assign px_read_data = rsp_data;

    function automatic logic [23:0] default_pix(input logic [15:0] a);
        return {a[7:0], ~a[15:8], a[15:8] ^ 8'h3C};
    endfunction

    function automatic logic [23:0] ref_read(input logic [15:0] a);
        if (model_mem.exists(int'(a))) return model_mem[int'(a)];
        return default_pix(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cpu_ready"}, cpu_ready, 1);
        check({tag, "_wdone"}, cpu_wdone, 0);
        check({tag, "_rvalid"}, cpu_rvalid, 0);
        check({tag, "_err"}, cpu_err, 0);
        check({tag, "_rdata"}, cpu_rdata, 0);
        check({tag, "_req"}, px_request_a, 0);
        check({tag, "_px_write"}, px_write, 0);
        check({tag, "_px_addr"}, px_address, 0);
        check({tag, "_px_wdata"}, px_write_data, 0);
        check({tag, "_state"}, dbg_state, 0);
    endtask

    // Offer one command until accepted; expectations are queued at acceptance.
    task automatic issue(input logic w, input logic [15:0] a, input logic [23:0] d, input bit silent);
        resp_t r;
        bit    done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            cpu_valid = 1'b1;
            cpu_write = w;
            cpu_addr  = a;
            cpu_wdata = d;
            #1;
            if (cpu_ready) begin
                r.write = w;
                if (silent) begin
                    r.err   = 1'b1;
                    r.rdata = 24'h0;
                end else begin
                    r.err = 1'b0;
                    if (w) begin
                        model_mem[int'(a)] = d;
                        r.rdata = 24'h0;
                    end else begin
                        r.rdata = ref_read(a);
                    end
                    px_exp_q.push_back('{w, a, d});
                end
                exp_q.push_back(r);
                @(posedge clk);
                #1;
                cpu_valid = 1'b0;
                done = 1;
            end
        end
        if (!done) begin
            cpu_valid = 1'b0;
            checks++;
            errors++;
            $display("FAIL issue_accept actual=not_accepted required=accepted addr=%0h", a);
        end
    endtask

    task automatic wait_idle();
        bit idle = 0;
        for (int i = 0; i < 3000 && !idle; i++) begin
            @(negedge clk);
            idle = (exp_q.size() == 0) && !px_request_a && !px_ready && (dbg_state == 2'd0);
        end
        if (!idle) begin
            checks++;
            errors++;
            $display("FAIL idle_wait actual=pending=%0d required=pending=0", exp_q.size());
        end
        repeat (SYNC + 2) @(negedge clk);
    endtask

    // Response scoreboard and four-phase monitor.
    always @(negedge clk) begin
        if (reset) begin
            if (cpu_wdone || cpu_rvalid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp actual=wdone%0d_rvalid%0d required=none", cpu_wdone, cpu_rvalid);
                end else begin
                    mon_r = exp_q.pop_front();
                    check("resp_kind_wdone", cpu_wdone, mon_r.write);
                    check("resp_kind_rvalid", cpu_rvalid, !mon_r.write);
                    check("resp_err", cpu_err, mon_r.err);
                    if (!mon_r.write) begin
                        check("read_data", cpu_rdata, mon_r.rdata);
                        last_rdata = mon_r.rdata;
                    end else begin
                        check("rdata_held", cpu_rdata, last_rdata);
                    end
                end
            end else if (cpu_err) begin
                checks++;
                errors++;
                $display("FAIL stray_err actual=1 required=0");
            end
            if (px_request_a && !prev_req) check("four_phase_rise", px_ready, 0);
        end
        prev_req = px_request_a;
    end

    // Responder: ready 3 pixel clocks after seeing the request, drops 2 after it falls.
    initial begin
        forever begin
            @(posedge pclk);
            if (rsp_en && px_request_a && !rsp_ready) begin
                repeat (3) @(posedge pclk);
                if (px_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req actual=addr%0h required=none", px_address);
                end else begin
                    rsp_c = px_exp_q.pop_front();
                    check("px_write", px_write, rsp_c.write);
                    check("px_address", px_address, rsp_c.addr);
                    if (rsp_c.write) check("px_write_data", px_write_data, rsp_c.wdata);
                end
                if (px_write) pix_mem[int'(px_address)] = px_write_data;
                else rsp_data = pix_mem.exists(int'(px_address)) ? pix_mem[int'(px_address)]
                                                                 : default_pix(px_address);
                rsp_ready = 1'b1;
                for (int i = 0; i < 200 && px_request_a; i++) begin
                    @(posedge pclk);
                    if (px_request_a) check("px_address_stable", px_address, rsp_c.addr);
                end
                if (px_request_a) begin
                    checks++;
                    errors++;
                    $display("FAIL req_drop actual=1 required=0");
                end
                repeat (2) @(posedge pclk);
                rsp_ready = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int          hi;
        logic [15:0] addr_tab[4];
        logic [15:0] a;
        addr_tab[0] = 16'h00FF;
        addr_tab[1] = 16'h1234;
        addr_tab[2] = 16'h0505;
        addr_tab[3] = 16'h7F80;
        model_mem[int'(16'h00FF)] = 24'h123456;
        pix_mem[int'(16'h00FF)]   = 24'h123456;
        reset = 1'b0;
        cpu_valid = 1'b0;
        cpu_write = 1'b0;
        cpu_addr  = 16'h0;
        cpu_wdata = 24'h0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b1;

        issue(1'b1, 16'h1234, 24'hABCDEF, 0);
        wait_idle();
        issue(1'b0, 16'h00FF, 24'h0, 0);
        wait_idle();

        issue(1'b1, 16'h0010, 24'h111111, 0);
        issue(1'b1, 16'h0011, 24'h222222, 0);
        check("ready_after_2nd", cpu_ready, 0);
        issue(1'b1, 16'h0012, 24'h333333, 0);
        wait_idle();

        rsp_en = 1'b0;
        issue(1'b1, 16'h0505, 24'h0BAD00, 1);
        hi = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (px_request_a) hi++;
            else if (hi > 0) break;
        end
        check("timeout_req_cycles", hi, TO);
        wait_idle();
        rsp_en = 1'b1;
        issue(1'b1, 16'h0505, 24'h5A5A5A, 0);
        issue(1'b0, 16'h0505, 24'h0, 0);
        wait_idle();

        issue(1'b0, 16'h00FF, 24'h0, 0);
        for (int i = 0; i < 500 && !rsp_ready; i++) @(posedge pclk);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_req");
        exp_q.delete();
        last_rdata = 24'h0;
        for (int i = 0; i < 200 && rsp_ready; i++) @(posedge pclk);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        wait_idle();

        @(negedge clk);
        spur = 1'b1;
        repeat (6) @(negedge clk);
        check("spur_state", dbg_state, 0);
        check("spur_req", px_request_a, 0);
        spur = 1'b0;
        repeat (SYNC + 3) @(negedge clk);
        issue(1'b0, 16'h1234, 24'h0, 0);
        wait_idle();

        for (int n = 0; n < 24; n++) begin
            a = ($urandom_range(0, 4) == 4) ? 16'($urandom) : addr_tab[$urandom_range(0, 3)];
            issue(1'($urandom_range(0, 1)), a, 24'($urandom), 0);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 15)) @(posedge clk);
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
